// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : fetch_queue
//  Description : Instruction fetch front-end. Owns the fetch PC, issues
//                in-order word requests to a variable-latency instruction
//                memory, buffers returned words with their PCs in a small
//                prefetch FIFO and hands them downstream over valid/ready.
//                Supports branch redirect (flush of queued and in-flight
//                wrong-path fetches) and latches the halt opcode 7'h7F.
//  Parameters  : DEPTH    - prefetch FIFO entries (power of two, >= 2);
//                           also caps in-flight plus buffered requests
//                RESET_PC - fetch PC after reset (4-byte aligned)
//  Ports       : clk, rst_n (async, active-low)
//                imem_req/imem_addr/imem_ready    - request channel
//                imem_rvalid/imem_rdata           - in-order response channel
//                redirect/redirect_pc             - branch redirect
//                out_valid/out_instr/out_pc/out_ready - downstream handshake
//                halted                           - halt delivered, fetch off
//  Options     : FETCH_BYPASS_EN - when defined, a response arriving while the
//                FIFO is empty and nothing is being discarded is presented
//                combinationally in the same cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        out_valid,
    output logic [31:0] out_instr,
    output logic [63:0] out_pc,
    input  logic        out_ready,
    output logic        halted
);

    localparam int c_AW   = $clog2(DEPTH);
    localparam int c_CW   = c_AW + 1;      // holds 0..DEPTH
    localparam int c_SUMW = c_CW + 1;

    logic [63:0]     r_fpc;
    logic [63:0]     r_rpc;
    logic [63:0]     r_pc_mem    [DEPTH];
    logic [31:0]     r_instr_mem [DEPTH];
    logic [c_AW-1:0] r_wr_ptr;
    logic [c_AW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic [c_CW-1:0] r_outstanding;
    logic [c_CW-1:0] r_discard;
    logic            r_halted;

    logic [c_SUMW-1:0] w_sum;
    logic [c_CW-1:0]   w_outst_nxt;
    logic [63:0]       w_redir_pc;
    logic              w_accept;
    logic              w_rsp;
    logic              w_redir;
    logic              w_rsp_live;
    logic              w_byp;
    logic              w_pop;
    logic              w_pop_fifo;
    logic              w_push;
    logic              w_halt_hit;
    logic              w_unused;

    assign w_unused   = &{1'b0, redirect_pc[1:0]};
    assign w_redir_pc = {redirect_pc[63:2], 2'b00};

    // Credits: buffered plus in-flight never exceeds DEPTH, so every
    // response is guaranteed a FIFO slot.
    assign w_sum     = c_SUMW'(r_count) + c_SUMW'(r_outstanding);
    assign imem_req  = rst_n && !r_halted && (w_sum < c_SUMW'(DEPTH));
    assign imem_addr = r_fpc;
    assign w_accept  = imem_req && imem_ready;

    // Responses with nothing tracked (e.g. stragglers from before a reset)
    // are ignored so the counters cannot underflow.
    assign w_rsp       = imem_rvalid && (r_outstanding != '0);
    assign w_outst_nxt = r_outstanding + c_CW'(w_accept) - c_CW'(w_rsp);

    assign w_redir    = redirect && !r_halted;
    // A response that belongs to the current path and may be delivered.
    assign w_rsp_live = w_rsp && (r_discard == '0) && !r_halted && !w_redir;

`ifdef FETCH_BYPASS_EN
    assign w_byp     = w_rsp && (r_discard == '0) && (r_count == '0) && !r_halted;
    assign out_valid = ((r_count != '0) || w_byp) && !r_halted;
    assign out_instr = w_byp ? imem_rdata : r_instr_mem[r_rd_ptr];
    assign out_pc    = w_byp ? r_rpc      : r_pc_mem[r_rd_ptr];
`else
    assign w_byp     = 1'b0;
    assign out_valid = (r_count != '0) && !r_halted;
    assign out_instr = r_instr_mem[r_rd_ptr];
    assign out_pc    = r_pc_mem[r_rd_ptr];
`endif

    // A redirect voids any same-cycle pop, including a would-be halt.
    assign w_pop      = out_valid && out_ready && !w_redir;
    assign w_pop_fifo = w_pop && !w_byp;
    assign w_push     = w_rsp_live && !(w_byp && w_pop);
    assign w_halt_hit = w_pop && (out_instr[6:0] == 7'h7F);
    assign halted     = r_halted;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fpc         <= RESET_PC;
            r_rpc         <= RESET_PC;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
            r_discard     <= '0;
            r_halted      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= '0;
                r_instr_mem[i] <= '0;
            end
        end else begin
            r_outstanding <= w_outst_nxt;
            if (w_redir) begin
                // Everything still in flight after this edge is wrong-path,
                // including a request accepted right now; a response arriving
                // right now is dropped here and so is not counted.
                r_fpc     <= w_redir_pc;
                r_rpc     <= w_redir_pc;
                r_wr_ptr  <= '0;
                r_rd_ptr  <= '0;
                r_count   <= '0;
                r_discard <= w_outst_nxt;
            end else begin
                if (w_accept) begin
                    r_fpc <= r_fpc + 64'd4;
                end
                if (w_rsp && (r_discard != '0)) begin
                    r_discard <= r_discard - c_CW'(1);
                end
                if (w_rsp_live) begin
                    r_rpc <= r_rpc + 64'd4;
                end
                if (w_push) begin
                    r_pc_mem[r_wr_ptr]    <= r_rpc;
                    r_instr_mem[r_wr_ptr] <= imem_rdata;
                    r_wr_ptr              <= r_wr_ptr + c_AW'(1);
                end
                if (w_pop_fifo) begin
                    r_rd_ptr <= r_rd_ptr + c_AW'(1);
                end
                r_count <= r_count + c_CW'(w_push) - c_CW'(w_pop_fifo);
                if (w_halt_hit) begin
                    r_halted <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fetch_queue
//  Description : Self-checking bench for fetch_queue (default build). A
//                latency-1 in-order memory model with an optional response
//                hold, a per-cycle vector table for the FIFO-fill sequence,
//                and a scoreboard of expected {pc, instr} deliveries.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_queue;

    localparam int          c_DEPTH = 4;
    localparam logic [63:0] c_RPC   = 64'h1000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = '0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        out_ready = 1'b0;
    logic        halted;

    fetch_queue #(.DEPTH(c_DEPTH), .RESET_PC(c_RPC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
        .out_ready(out_ready), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct { logic [63:0] addr; int due; } pend_t;
    typedef struct { logic [63:0] pc; logic [31:0] instr; } exp_t;
    typedef struct {
        logic        ordy;
        logic        exp_req;
        logic [63:0] exp_addr;
        logic        exp_valid;
        logic [63:0] exp_pc;
    } vec_t;

    pend_t       pend[$];
    exp_t        sb[$];
    vec_t        tbl[11];
    int          cyc = 0;
    int          n_total = 0;
    int          n_pass = 0;
    logic        rsp_hold = 1'b0;
    logic [63:0] halt_addr = 64'hFFFF_FFFF_FFFF_FFF0;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == halt_addr) return 32'h0000_007F;
        return {a[23:0], 8'h13};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic sb_push(input logic [63:0] pc);
        exp_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        sb.push_back(e);
    endtask

    // Called at a falling edge: drive the memory response, then settle.
    task automatic begin_cycle();
        if (rst_n && !rsp_hold && pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        #1;
    endtask

    // Record what happens at the coming rising edge, then move to the next
    // falling edge.
    task automatic end_cycle();
        exp_t e;
        #3;
        if (rst_n) begin
            if (imem_rvalid) void'(pend.pop_front());
            if (imem_req && imem_ready) pend.push_back('{addr: imem_addr, due: cyc + 1});
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_total++;
                    $display("FAIL sb_extra: got pc %h instr %h expected no output", out_pc, out_instr);
                end else begin
                    e = sb.pop_front();
                    chk("sb_pc", out_pc, e.pc);
                    chk("sb_instr", {32'b0, out_instr}, {32'b0, e.instr});
                end
            end
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic apply_reset();
        rst_n       = 1'b0;
        redirect    = 1'b0;
        out_ready   = 1'b0;
        rsp_hold    = 1'b0;
        imem_ready  = 1'b1;
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
        pend.delete();
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    initial begin
        // FIFO fill then drain with out_ready held low for cycles 0..6.
        tbl[0]  = '{1'b0, 1'b1, 64'h1000, 1'b0, 64'h0};
        tbl[1]  = '{1'b0, 1'b1, 64'h1004, 1'b0, 64'h0};
        tbl[2]  = '{1'b0, 1'b1, 64'h1008, 1'b1, 64'h1000};
        tbl[3]  = '{1'b0, 1'b1, 64'h100C, 1'b1, 64'h1000};
        tbl[4]  = '{1'b0, 1'b0, 64'h1010, 1'b1, 64'h1000};
        tbl[5]  = '{1'b0, 1'b0, 64'h1010, 1'b1, 64'h1000};
        tbl[6]  = '{1'b0, 1'b0, 64'h1010, 1'b1, 64'h1000};
        tbl[7]  = '{1'b1, 1'b0, 64'h1010, 1'b1, 64'h1000};
        tbl[8]  = '{1'b1, 1'b1, 64'h1010, 1'b1, 64'h1004};
        tbl[9]  = '{1'b1, 1'b1, 64'h1014, 1'b1, 64'h1008};
        tbl[10] = '{1'b1, 1'b1, 64'h1018, 1'b1, 64'h100C};

        @(negedge clk);
        // Reset values.
        apply_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_req", {63'b0, imem_req}, 64'd0);
        chk("rst_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_halted", {63'b0, halted}, 64'd0);
        chk("rst_addr", imem_addr, c_RPC);
        chk("rst_instr", {32'b0, out_instr}, 64'd0);
        chk("rst_pc", out_pc, 64'd0);
        @(negedge clk);

        // Streaming at one instruction per cycle.
        apply_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) sb_push(c_RPC + 64'(4 * k));
        for (int k = 0; k < 10; k++) begin
            begin_cycle();
            chk("stream_req", {63'b0, imem_req}, 64'd1);
            chk("stream_addr", imem_addr, c_RPC + 64'(4 * k));
            end_cycle();
        end
        out_ready = 1'b0;
        chk("stream_sb_left", 64'(sb.size()), 64'd0);

        // Fill to DEPTH, stall, then drain and resume.
        apply_reset();
        for (int k = 0; k < 4; k++) sb_push(c_RPC + 64'(4 * k));
        for (int i = 0; i < 11; i++) begin
            out_ready = tbl[i].ordy;
            begin_cycle();
            chk("fill_req", {63'b0, imem_req}, {63'b0, tbl[i].exp_req});
            chk("fill_addr", imem_addr, tbl[i].exp_addr);
            chk("fill_valid", {63'b0, out_valid}, {63'b0, tbl[i].exp_valid});
            if (tbl[i].exp_valid) chk("fill_pc", out_pc, tbl[i].exp_pc);
            end_cycle();
        end
        out_ready = 1'b0;
        chk("fill_sb_left", 64'(sb.size()), 64'd0);

        // Redirect with 2 queued and 2 in flight.
        apply_reset();
        for (int k = 0; k < 5; k++) begin
            rsp_hold = (k >= 3);
            begin_cycle();
            end_cycle();
        end
        begin_cycle();
        chk("rd1_req_full", {63'b0, imem_req}, 64'd0);
        chk("rd1_valid_pre", {63'b0, out_valid}, 64'd1);
        redirect    = 1'b1;
        redirect_pc = 64'h2002;
        end_cycle();
        redirect  = 1'b0;
        rsp_hold  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) sb_push(64'h2000 + 64'(4 * k));
        for (int k = 0; k < 10; k++) begin
            begin_cycle();
            if (k == 0) chk("rd1_first_addr", imem_addr, 64'h2000);
            if (k < 3) chk("rd1_no_stale", {63'b0, out_valid}, 64'd0);
            end_cycle();
        end
        out_ready = 1'b0;
        chk("rd1_sb_left", 64'(sb.size()), 64'd0);

        // Redirect coinciding with an accepted request and an arriving response.
        apply_reset();
        out_ready = 1'b1;
        begin_cycle();
        end_cycle();
        begin_cycle();
        chk("rd2_rsp_arrives", {63'b0, imem_rvalid}, 64'd1);
        chk("rd2_req_same", {63'b0, imem_req}, 64'd1);
        redirect    = 1'b1;
        redirect_pc = 64'h3000;
        end_cycle();
        redirect = 1'b0;
        for (int k = 0; k < 8; k++) sb_push(64'h3000 + 64'(4 * k));
        for (int k = 0; k < 10; k++) begin
            begin_cycle();
            if (k == 0) chk("rd2_first_addr", imem_addr, 64'h3000);
            if (k < 2) chk("rd2_no_stale", {63'b0, out_valid}, 64'd0);
            end_cycle();
        end
        out_ready = 1'b0;
        chk("rd2_sb_left", 64'(sb.size()), 64'd0);

        // Halt opcode at 0x1008.
        apply_reset();
        halt_addr = 64'h1008;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) sb_push(c_RPC + 64'(4 * k));
        for (int k = 0; k < 5; k++) begin
            begin_cycle();
            if (k == 4) chk("halt_not_yet", {63'b0, halted}, 64'd0);
            end_cycle();
        end
        for (int k = 5; k < 10; k++) begin
            redirect    = (k == 6);
            redirect_pc = 64'h4000;
            begin_cycle();
            chk("halt_flag", {63'b0, halted}, 64'd1);
            chk("halt_no_valid", {63'b0, out_valid}, 64'd0);
            chk("halt_no_req", {63'b0, imem_req}, 64'd0);
            if (k == 7) chk("halt_redir_ignored", imem_addr, 64'h1014);
            end_cycle();
        end
        redirect = 1'b0;
        chk("halt_sb_left", 64'(sb.size()), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("halt_rst_clears", {63'b0, halted}, 64'd0);
        halt_addr = 64'hFFFF_FFFF_FFFF_FFF0;

        // Reset with a full FIFO, then restart at RESET_PC.
        apply_reset();
        for (int k = 0; k < 8; k++) begin
            begin_cycle();
            if (k == 7) begin
                chk("full_valid", {63'b0, out_valid}, 64'd1);
                chk("full_req", {63'b0, imem_req}, 64'd0);
            end
            end_cycle();
        end
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {63'b0, out_valid}, 64'd0);
        chk("midrst_req", {63'b0, imem_req}, 64'd0);
        chk("midrst_halted", {63'b0, halted}, 64'd0);
        apply_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) sb_push(c_RPC + 64'(4 * k));
        for (int k = 0; k < 8; k++) begin
            begin_cycle();
            if (k == 0) begin
                chk("restart_req", {63'b0, imem_req}, 64'd1);
                chk("restart_addr", imem_addr, c_RPC);
                chk("restart_valid", {63'b0, out_valid}, 64'd0);
            end
            end_cycle();
        end
        out_ready = 1'b0;
        chk("restart_sb_left", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
